// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority encoder.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width; a 2-input encoder still needs one bit.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/prio_search.sv
// Combinational search: first set bit walking down from top_i with wrap-around.
module prio_search
    import prio_enc_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] top_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] masked_s;
    logic [N-1:0] rot_s;
    int           top_s;
    int           src_s;
    int           sel_s;
    int           win_s;

    // Rotate so that top lands in bit N-1, take the highest set bit, rotate back.
    always_comb begin
        masked_s = req_i & ~excl_i;
        top_s    = (int'(top_i) >= N) ? (N - 1) : int'(top_i);
        rot_s    = '0;
        src_s    = 0;
        for (int j = 0; j < N; j++) begin
            src_s    = top_s + 1 + j;
            src_s    = (src_s >= N) ? (src_s - N) : src_s;
            rot_s[j] = masked_s[IW'(src_s)];
        end
        sel_s = 0;
        for (int j = 0; j < N; j++) begin
            sel_s = rot_s[j] ? j : sel_s;
        end
        win_s   = top_s + 1 + sel_s;
        win_s   = (win_s >= N) ? (win_s - N) : win_s;
        found_o = |rot_s;
        idx_o   = IW'(win_s);
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder/arbiter with fixed or round-robin order
// and a valid/ready grant handshake that never withdraws a presented grant.
module prio_enc_rr
    import prio_enc_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = idx_width(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          rr_en_i,
    input  logic          gnt_ready_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic [N-1:0]  gnt_onehot_o
);

    localparam logic [IW-1:0] TOP_FIXED = IW'(N - 1);

    logic          gnt_valid_q, gnt_valid_d;
    logic [IW-1:0] gnt_idx_q,   gnt_idx_d;
    logic [N-1:0]  gnt_onehot_q, gnt_onehot_d;
    logic [IW-1:0] ptr_q,       ptr_d;

    logic          accept_s;
    logic          load_s;
    logic          rr_mode_s;
    logic [IW-1:0] top_s;
    logic [N-1:0]  others_s;
    logic [N-1:0]  excl_s;
    logic          found_s;
    logic [IW-1:0] win_idx_s;

    // Search control: the just-accepted index is skipped in round-robin
    // unless it is the only requester, so a lone request keeps full rate.
    always_comb begin
        rr_mode_s = (rr_en_i == MODE_RR);
        accept_s  = gnt_valid_q & gnt_ready_i;
        load_s    = ~gnt_valid_q | gnt_ready_i;
        top_s     = rr_mode_s ? ptr_q : TOP_FIXED;
        others_s  = req_i & ~gnt_onehot_q;
        if (accept_s && rr_mode_s && (|others_s)) begin
            excl_s = gnt_onehot_q;
        end else begin
            excl_s = '0;
        end
    end

    prio_search #(
        .N  (N),
        .IW (IW)
    ) u_search (
        .req_i   (req_i),
        .top_i   (top_s),
        .excl_i  (excl_s),
        .found_o (found_s),
        .idx_o   (win_idx_s)
    );

    // Grant register and pointer next-state.
    always_comb begin
        gnt_valid_d  = gnt_valid_q;
        gnt_idx_d    = gnt_idx_q;
        gnt_onehot_d = gnt_onehot_q;
        ptr_d        = ptr_q;
        if (load_s) begin
            if (found_s) begin
                gnt_valid_d             = 1'b1;
                gnt_idx_d               = win_idx_s;
                gnt_onehot_d            = '0;
                gnt_onehot_d[win_idx_s] = 1'b1;
            end else begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = '0;
            end
        end else begin
            gnt_valid_d = gnt_valid_q;
        end
        if (accept_s && rr_mode_s) begin
            ptr_d = (gnt_idx_q == '0) ? TOP_FIXED : (gnt_idx_q - IW'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers; reset discards any held grant immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_valid_q  <= 1'b0;
            gnt_idx_q    <= '0;
            gnt_onehot_q <= '0;
            ptr_q        <= TOP_FIXED;
        end else begin
            gnt_valid_q  <= gnt_valid_d;
            gnt_idx_q    <= gnt_idx_d;
            gnt_onehot_q <= gnt_onehot_d;
            ptr_q        <= ptr_d;
        end
    end

    assign gnt_valid_o  = gnt_valid_q;
    assign gnt_idx_o    = gnt_idx_q;
    assign gnt_onehot_o = gnt_onehot_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Directed bench for prio_enc_rr: table of N=8 vectors plus hand-written
// sequences for N=3 fixed order, pointer wrap and asynchronous reset.
module tb_prio_enc_rr;

    typedef struct {
        logic [7:0] req;
        logic       rr;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_idx;
        logic [7:0] exp_oh;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req8;
    logic       rr8, rdy8;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [2:0] req3;
    logic       rr3, rdy3;
    logic       v3;
    logic [1:0] idx3;
    logic [2:0] oh3;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t tbl[14];

    always #5 clk = ~clk;

    prio_enc_rr #(.N(8)) u_dut8 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req8),
        .rr_en_i      (rr8),
        .gnt_ready_i  (rdy8),
        .gnt_valid_o  (v8),
        .gnt_idx_o    (idx8),
        .gnt_onehot_o (oh8)
    );

    prio_enc_rr #(.N(3)) u_dut3 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req3),
        .rr_en_i      (rr3),
        .gnt_ready_i  (rdy3),
        .gnt_valid_o  (v3),
        .gnt_idx_o    (idx3),
        .gnt_onehot_o (oh3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string nm, input logic ev, input logic [2:0] ei, input logic [7:0] eo);
        chk({nm, ".valid"}, 32'(v8), 32'(ev));
        chk({nm, ".onehot"}, 32'(oh8), 32'(eo));
        if (ev) begin
            chk({nm, ".idx"}, 32'(idx8), 32'(ei));
        end
    endtask

    task automatic chk3(input string nm, input logic ev, input logic [1:0] ei, input logic [2:0] eo);
        chk({nm, ".valid"}, 32'(v3), 32'(ev));
        chk({nm, ".onehot"}, 32'(oh3), 32'(eo));
        if (ev) begin
            chk({nm, ".idx"}, 32'(idx3), 32'(ei));
        end
    endtask

    initial begin
        // Starts with a 7 held (ready low). Fixed then round-robin on 1001_0010.
        tbl[0]  = '{8'h20, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20};
        tbl[1]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tbl[2]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tbl[3]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tbl[4]  = '{8'h01, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20};
        tbl[5]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01};
        tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[7]  = '{8'h92, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tbl[8]  = '{8'h92, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10};
        tbl[9]  = '{8'h92, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02};
        tbl[10] = '{8'h92, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80};
        tbl[11] = '{8'h92, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10};
        tbl[12] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[13] = '{8'h92, 1'b1, 1'b0, 1'b1, 3'd1, 8'h02};

        rst  = 1'b1;
        req8 = 8'hFF;
        rr8  = 1'b0;
        rdy8 = 1'b0;
        req3 = 3'b111;
        rr3  = 1'b0;
        rdy3 = 1'b0;

        step();
        chk("rst8.valid", 32'(v8), 32'd0);
        chk("rst8.idx", 32'(idx8), 32'd0);
        chk("rst8.onehot", 32'(oh8), 32'd0);
        chk("rst8.ptr", 32'(u_dut8.ptr_q), 32'd7);
        chk("rst3.valid", 32'(v3), 32'd0);

        req3 = 3'b000;
        rst  = 1'b0;
        step();
        chk8("rel8", 1'b1, 3'd7, 8'h80);

        // N=3 fixed priority, ready high.
        rdy3 = 1'b1;
        req3 = 3'b011; step(); chk3("fix3_a", 1'b1, 2'd1, 3'b010);
        req3 = 3'b001; step(); chk3("fix3_b", 1'b1, 2'd0, 3'b001);
        req3 = 3'b100; step(); chk3("fix3_c", 1'b1, 2'd2, 3'b100);
        req3 = 3'b000; step(); chk3("fix3_d", 1'b0, 2'd0, 3'b000);
        chk8("held8", 1'b1, 3'd7, 8'h80);

        for (int i = 0; i < 14; i++) begin
            req8 = tbl[i].req;
            rr8  = tbl[i].rr;
            rdy8 = tbl[i].rdy;
            step();
            chk8($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_idx, tbl[i].exp_oh);
        end
        chk("ptr_before_rst", 32'(u_dut8.ptr_q), 32'd3);

        // Asynchronous reset between edges while a round-robin grant is held.
        #3;
        rst = 1'b1;
        #1;
        chk8("async_rst", 1'b0, 3'd0, 8'h00);
        chk("async_rst.idx", 32'(idx8), 32'd0);
        chk("async_rst.ptr", 32'(u_dut8.ptr_q), 32'd7);
        #1;
        rst = 1'b0;
        step();
        chk8("post_rst", 1'b1, 3'd7, 8'h80);

        // Pointer wrap: accept 7 -> 1, accept 1 -> 0, accept 0 -> ptr back to 7.
        req8 = 8'h03;
        rdy8 = 1'b1;
        step(); chk8("wrap_a", 1'b1, 3'd1, 8'h02);
        chk("wrap_a.ptr", 32'(u_dut8.ptr_q), 32'd6);
        step(); chk8("wrap_b", 1'b1, 3'd0, 8'h01);
        chk("wrap_b.ptr", 32'(u_dut8.ptr_q), 32'd0);
        step(); chk8("wrap_c", 1'b1, 3'd1, 8'h02);
        chk("wrap_c.ptr", 32'(u_dut8.ptr_q), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_enc_rr.md
# prio_enc_rr

Parametrised, registered priority encoder/arbiter: the N-input successor to the team's 3-input combinational priority encoder. It selects one active request per arbitration, presents its binary index and one-hot grant on a valid/ready handshake, and holds the grant stable under backpressure. A run-time mode input selects either fixed priority (highest index wins, the same ordering as the 3-input encoder) or round-robin. It sits between request sources (interrupt lines, channel requests) and a single consumer that accepts one grant per cycle.

## Interface
- `N`, default 8: number of request lines, N ≥ 2.
- `IW`, default `$clog2(N)`: width of the grant index, derived and not overridden.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  request vector; level-sensitive, sampled every cycle.
- `rr_en`  in  1  0 = fixed priority (index N-1 highest), 1 = round-robin.
- `gnt_valid`  out  1  a grant is presented.
- `gnt_idx`  out  IW  binary index of the granted request.
- `gnt_onehot`  out  N  equals `1 << gnt_idx` when `gnt_valid`, else all zeros.
- `gnt_ready`  in  1  the consumer accepts the grant when this and `gnt_valid` are both 1.

## Operation
- State: grant register (valid, idx) and priority pointer `ptr` (IW bits). `ptr` names the highest-priority index.
- Search order runs from `top`, then top-1 down to 0, then wraps to N-1, and so on. The first set `req` bit in that order wins.
  - `top = N-1` when `rr_en=0`.
  - `top = ptr` when `rr_en=1`.
- Load condition: `!gnt_valid || gnt_ready`. When the load condition holds:
  - If `|req`, the grant register loads the winner and sets `gnt_valid=1`.
  - Otherwise, `gnt_valid` is cleared.
- Hold: when `gnt_valid && !gnt_ready`, `gnt_idx` and `gnt_onehot` stay frozen, even if `req` changes or the granted bit drops. A grant is never withdrawn once it is presented.
- Pointer update: only on an accept (`gnt_valid && gnt_ready`) with `rr_en=1`. Then `ptr <= (gnt_idx==0) ? N-1 : gnt_idx-1`.
  - The new `ptr` applies to the search in the following cycle. The back-to-back reload in the accept cycle uses the pre-update pointer with the accepted index excluded from the search.
- `rr_en=0` freezes `ptr`. Toggling `rr_en` takes effect at the next load and never alters a held grant.
- Reset values: `gnt_valid=0`, `gnt_idx=0`, `gnt_onehot=0`, `ptr=N-1`. Reset acts immediately (asynchronous), including mid-handshake; the held grant is discarded.

## Timing
- Latency: a request present at edge k appears as a grant after edge k (one register stage). Outputs are registered; no combinational path runs from `req` to any output.
- Throughput: one grant per cycle with `gnt_ready` tied high.
- Back-to-back: on the accept edge the next winner loads in the same edge, with no bubble.
- Empty: if `req=0` on the accept edge, `gnt_valid` falls the next cycle.
- Pointer wrap: accepting index 0 sets `ptr` to N-1.
- Simultaneous: a request rising in the same cycle the held grant is accepted participates in that cycle's search.

## Structure
- Package `prio_enc_pkg`: index-width helper function (returns 1 for N ≤ 2) and the mode encoding constants `MODE_FIXED=0` and `MODE_RR=1`.
- Sub-module `prio_search`: purely combinational. Inputs are `req`, `top` and an exclude mask; outputs are `found` and `idx`. Implementation: rotate, run a fixed highest-index find, then un-rotate.
- The top level holds only the grant register, pointer and handshake logic.

## Test plan
- Reset: `rst=1` with `req=8'hFF` gives all outputs 0. Release `rst` with `rr_en=0`: after the next edge `gnt_valid=1`, `gnt_idx=7`, `gnt_onehot=8'h80`.
- Fixed priority, N=3, `gnt_ready=1`: `req` sequence 3'b011, 3'b001, 3'b100, 3'b000 yields `gnt_idx` 1, 0, 2, then `gnt_valid=0`.
- Backpressure: grant `idx=5` is presented; hold `gnt_ready=0` for 4 cycles while `req` changes to 8'h01. `gnt_idx` stays 5 and `gnt_valid` stays 1 throughout. After `gnt_ready=1`, the next grant is `idx=0`.
- Round-robin: `rr_en=1`, `req=8'b1001_0010` held, `gnt_ready=1`. Grants run 7, 4, 1, 7, 4 with no bubbles. Accepting idx 1 then idx 0 shows the wrap to `ptr=7`.
- Reset mid-grant: assert `rst` asynchronously between edges while `gnt_valid=1`, `rr_en=1`, `ptr=3`. Outputs go to 0 before the next edge and `ptr=7`; the first grant after release follows fixed order.
